// File: rtl/acc_pkg.sv
// Shared state encoding and default widths for the operand accumulator.
// Optional build macro used by the accumulator: ACC_SATURATE_EN.
package acc_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/add_stage.sv
// Combinational unsigned adder used as the accumulator's single add stage.
// Produces a W-bit sum and the carry-out of the top bit.
module add_stage #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = total[W-1:0];
  assign cout  = total[W];

endmodule

// File: rtl/operand_accumulator.sv
// Sums a counted stream of unsigned operands, one per cycle, and returns {carry count, sum}.
// Build macro ACC_SATURATE_EN: clamp to all-ones with a sticky flag instead of counting carries.
module operand_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_ops,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic [COUNT_W-1:0] out_carry,
  output logic               out_sat,
  output logic               busy
);

  acc_state_e         state_q;
  acc_state_e         state_d;
  logic [DATA_W-1:0]  acc_q;
  logic [COUNT_W-1:0] carry_q;
  logic [COUNT_W-1:0] remaining_q;
  logic [DATA_W-1:0]  add_sum;
  logic               add_cout;
  logic               accept;
  logic               launch;
  logic               last_op;

  assign launch  = (state_q == IDLE) && start;
  assign accept  = (state_q == ACCUM) && in_valid;
  assign last_op = (remaining_q == {{(COUNT_W-1){1'b0}}, 1'b1});

  add_stage #(
    .W (DATA_W)
  ) u_add_stage (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_ops != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (accept && last_op) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_q <= '0;
    end else if (launch) begin
      remaining_q <= num_ops;
    end else if (accept) begin
      remaining_q <= remaining_q - {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ACC_SATURATE_EN
  logic sat_q;

  // Once saturated the sum stays pinned; the carry count is never used here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= '0;
      sat_q   <= 1'b0;
    end else if (launch) begin
      acc_q   <= '0;
      carry_q <= '0;
      sat_q   <= 1'b0;
    end else if (accept) begin
      if (add_cout || sat_q) begin
        acc_q <= '1;
        sat_q <= 1'b1;
      end else begin
        acc_q <= add_sum;
      end
    end
  end

  assign out_sat = sat_q;
`else
  // Carry count is the high part of the true sum; it cannot wrap for legal num_ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= '0;
    end else if (launch) begin
      acc_q   <= '0;
      carry_q <= '0;
    end else if (accept) begin
      acc_q   <= add_sum;
      carry_q <= carry_q + {{(COUNT_W-1){1'b0}}, add_cout};
    end
  end

  assign out_sat = 1'b0;
`endif

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_operand_accumulator.sv
// Randomized bench for operand_accumulator against an arithmetic reference model.
module tb_operand_accumulator;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_ops;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic [CW-1:0] out_carry;
  logic          out_sat;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ops_q[$];

  operand_accumulator #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rdy"},   longint'(in_ready),  0);
    check_val({tag, "_vld"},   longint'(out_valid), 0);
    check_val({tag, "_busy"},  longint'(busy),      0);
    check_val({tag, "_sum"},   longint'(out_sum),   0);
    check_val({tag, "_carry"}, longint'(out_carry), 0);
    check_val({tag, "_sat"},   longint'(out_sat),   0);
  endtask

  // One full run over ops_q: gap_pct = chance of an idle in_valid cycle,
  // hold = cycles out_ready stays low in DONE, noise = stray start pulses.
  task automatic run(input int gap_pct, input int hold, input bit noise);
    int     n;
    int     idx;
    int     budget;
    longint total;
    longint exp_sum;
    longint exp_carry;
    longint exp_sat;
    bit     v;

    n     = ops_q.size();
    total = 0;
    foreach (ops_q[i]) total += longint'(ops_q[i]);
`ifdef ACC_SATURATE_EN
    if (total >= (64'd1 << DW)) begin
      exp_sum = (64'd1 << DW) - 1; exp_carry = 0; exp_sat = 1;
    end else begin
      exp_sum = total; exp_carry = 0; exp_sat = 0;
    end
`else
    exp_sum   = total % (64'd1 << DW);
    exp_carry = total >> DW;
    exp_sat   = 0;
`endif

    check_val("idle_busy", longint'(busy), 0);
    check_val("idle_rdy",  longint'(in_ready), 0);
    start     = 1'b1;
    num_ops   = CW'(n);
    out_ready = (hold == 0);
    tick();
    start   = 1'b0;
    num_ops = CW'($urandom);

    if (n == 0) check_val("zero_no_rdy", longint'(in_ready), 0);

    idx    = 0;
    budget = 0;
    while (idx < n && budget < 20 * n + 50) begin
      check_val("accum_rdy", longint'(in_ready), 1);
      check_val("accum_no_vld", longint'(out_valid), 0);
      v        = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? ops_q[idx] : DW'($urandom);
      if (noise) begin
        start   = 1'($urandom_range(1));
        num_ops = CW'($urandom);
      end
      tick();
      if (v) idx++;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < n) check_val("op_timeout", idx, n);

    check_val("done_vld",   longint'(out_valid), 1);
    check_val("done_rdy",   longint'(in_ready),  0);
    check_val("done_busy",  longint'(busy),      1);
    check_val("done_sum",   longint'(out_sum),   exp_sum);
    check_val("done_carry", longint'(out_carry), exp_carry);
    check_val("done_sat",   longint'(out_sat),   exp_sat);

    for (int h = 0; h < hold; h++) begin
      if (noise) start = 1'($urandom_range(1));
      tick();
      check_val("hold_vld",   longint'(out_valid), 1);
      check_val("hold_sum",   longint'(out_sum),   exp_sum);
      check_val("hold_carry", longint'(out_carry), exp_carry);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("release_vld",  longint'(out_valid), 0);
    check_val("release_busy", longint'(busy),      0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    ops_q = {16'd10, 16'd20, 16'd30};
    run(0, 0, 1'b0);

    ops_q = {16'hFFFF, 16'h0002};
    run(0, 0, 1'b0);

    ops_q = {};
    run(0, 0, 1'b0);

    ops_q = {};
    for (int i = 0; i < 4; i++) ops_q.push_back(DW'($urandom));
    run(50, 5, 1'b1);

    // Reset in the middle of a run discards everything.
    start   = 1'b1;
    num_ops = CW'(4);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_data  = 16'hF00D;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    check_val("midrst_idle", longint'(busy), 0);
    ops_q = {16'd5, 16'd7};
    run(0, 0, 1'b0);

    ops_q = {};
    for (int i = 0; i < 255; i++) ops_q.push_back(16'hFFFF);
    run(0, 1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      ops_q = {};
      for (int i = 0; i < int'($urandom_range(20)); i++) begin
        ops_q.push_back(($urandom_range(1) == 1) ? DW'($urandom) : DW'($urandom_range(255)));
      end
      run(int'($urandom_range(60)), int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
